// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - op encodings, iteration count and FSM state type for the multiply/divide unit
package mul_div_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int MD_ITERS = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  function automatic logic md_is_iterative(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - issue/result bundle between the execute stage and the multiply/divide unit
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, hi, lo);
  modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, one bit per cycle
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  mul_div_unit_if.slave md
);

  localparam int ITERS = MD_ITERS;
  localparam int CW    = $clog2(ITERS);

  md_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               bzero_q, bzero_d;

  logic               last;
  logic               sgn;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     add_sum, rem_sh, diff;
  logic [2*WIDTH-1:0] mul_next, div_next, step, prod;
  logic [WIDTH-1:0]   quo, rem;

  assign last  = (cnt_q == CW'(ITERS - 1));
  assign sgn   = (md.op == MD_MULT) || (md.op == MD_DIV);
  assign mag_a = (sgn && md.a[WIDTH-1]) ? -md.a : md.a;
  assign mag_b = (sgn && md.b[WIDTH-1]) ? -md.b : md.b;

  // Multiply: sr = {accumulator, remaining multiplier bits}, shifted right with the add carry.
  assign add_sum  = {1'b0, sr_q[2*WIDTH-1:WIDTH]} + (sr_q[0] ? {1'b0, m_q} : '0);
  assign mul_next = {add_sum, sr_q[WIDTH-1:1]};

  // Divide: sr = {remainder, dividend/quotient}, shifted left; restore by simply not subtracting.
  assign rem_sh   = sr_q[2*WIDTH-1:WIDTH-1];
  assign diff     = rem_sh - {1'b0, m_q};
  assign div_next = diff[WIDTH] ? {rem_sh[WIDTH-1:0], sr_q[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0],   sr_q[WIDTH-2:0], 1'b1};

  assign step = is_div_q ? div_next : mul_next;
  assign prod = neg_q ? -step : step;
  assign quo  = neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
  assign rem  = rem_neg_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (md.start && md_is_iterative(md.op)) state_d = ST_RUN;
      ST_RUN:  if (last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    md.busy = (state_q == ST_RUN);
    md.hi   = hi_q;
    md.lo   = lo_q;
  end

  always_comb begin
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    m_d       = m_q;
    a_d       = a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    bzero_d   = bzero_q;
    if (state_q == ST_IDLE) begin
      if (md.start && md_is_iterative(md.op)) begin
        is_div_d  = (md.op == MD_DIV) || (md.op == MD_DIVU);
        neg_d     = sgn && (md.a[WIDTH-1] ^ md.b[WIDTH-1]);
        rem_neg_d = sgn && md.a[WIDTH-1];
        bzero_d   = (md.b == '0);
        a_d       = md.a;
        cnt_d     = '0;
        m_d       = is_div_d ? mag_b : mag_a;
        sr_d      = {{WIDTH{1'b0}}, (is_div_d ? mag_a : mag_b)};
      end else if (md.start && md.op == MD_MTHI) begin
        hi_d = md.a;
      end else if (md.start && md.op == MD_MTLO) begin
        lo_d = md.a;
      end
    end else begin
      sr_d  = step;
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        if (!is_div_q) begin
          {hi_d, lo_d} = prod;
        end else if (bzero_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      sr_q      <= '0;
      m_q       <= '0;
      a_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      bzero_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      m_q       <= m_d;
      a_q       <= a_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      bzero_q   <= bzero_d;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit: spec vectors, corner sequences, random vs model
module tb_mul_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(32)) md();
  mul_div_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .md(md));

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cycles);
    @(negedge clk);
    md.start = 1'b1; md.op = op; md.a = a; md.b = b;
    @(negedge clk);
    md.start = 1'b0;
    busy_cycles = 0;
    while (md.busy && busy_cycles < 100) begin
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint x, y;
    int     q, r;
    case (op)
      3'd0: begin
        x = longint'($signed(a));
        y = longint'($signed(b));
        return 64'(x * y);
      end
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      3'd4: return {a, lo};
      3'd5: return {hi, a};
      default: return {hi, lo};
    endcase
  endfunction

  initial begin
    int          bc;
    logic [31:0] m_hi, m_lo;
    logic [63:0] r64;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    md.start = 1'b0; md.op = 3'd0; md.a = '0; md.b = '0;

    vecs.push_back('{"mult_m3x5",    3'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1});
    vecs.push_back('{"multu_max",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{"divu_100_7",   3'd3, 32'd100,       32'd7,         32'd2,         32'd14});
    vecs.push_back('{"div_m7_2",     3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{"div_overflow", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000});
    vecs.push_back('{"divu_by_zero", 3'd3, 32'h1234,      32'h0,         32'h1234,      32'hFFFF_FFFF});
    vecs.push_back('{"div_by_zero",  3'd2, 32'hFFFF_FF00, 32'h0,         32'hFFFF_FF00, 32'hFFFF_FFFF});
    vecs.push_back('{"div_m9_m4",    3'd2, 32'hFFFF_FFF7, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'd2});

    // reset held for two cycles
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hi", md.hi, 32'd0);
    check("reset_lo", md.lo, 32'd0);
    check("reset_busy", 32'(md.busy), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, bc);
      check({vecs[i].name, "_busy_cycles"}, 32'(bc), 32'd32);
      check({vecs[i].name, "_hi"}, md.hi, vecs[i].exp_hi);
      check({vecs[i].name, "_lo"}, md.lo, vecs[i].exp_lo);
    end

    // MTHI then MTLO on consecutive edges
    @(negedge clk);
    md.start = 1'b1; md.op = 3'd4; md.a = 32'hDEAD_BEEF;
    @(negedge clk);
    check("mthi_hi", md.hi, 32'hDEAD_BEEF);
    check("mthi_busy", 32'(md.busy), 32'd0);
    md.op = 3'd5; md.a = 32'h0BAD_F00D;
    @(negedge clk);
    md.start = 1'b0;
    check("mtlo_lo", md.lo, 32'h0BAD_F00D);
    check("mtlo_hi_kept", md.hi, 32'hDEAD_BEEF);
    check("mtlo_busy", 32'(md.busy), 32'd0);

    // MULT 6x7 with a DIVU and an MTHI attempted while busy; HI/LO must not move mid-run
    @(negedge clk);
    md.start = 1'b1; md.op = 3'd0; md.a = 32'd6; md.b = 32'd7;
    @(negedge clk);
    md.start = 1'b0;
    bc = 0;
    while (md.busy && bc < 100) begin
      bc++;
      if (bc == 5) begin md.start = 1'b1; md.op = 3'd3; md.a = 32'd100; md.b = 32'd7; end
      else if (bc == 6) begin md.op = 3'd4; md.a = 32'h5555_5555; end
      else md.start = 1'b0;
      if (bc == 20) check("midrun_hi_held", md.hi, 32'hDEAD_BEEF);
      @(negedge clk);
    end
    md.start = 1'b0;
    check("ignored_busy_cycles", 32'(bc), 32'd32);
    check("ignored_lo", md.lo, 32'd42);
    check("ignored_hi", md.hi, 32'd0);
    @(negedge clk);
    check("ignored_no_restart", 32'(md.busy), 32'd0);

    // reset at cycle 10 of a DIV
    @(negedge clk);
    md.start = 1'b1; md.op = 3'd2; md.a = 32'hFFFF_FF9C; md.b = 32'd7;
    @(negedge clk);
    md.start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_busy_before", 32'(md.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(md.busy), 32'd0);
    check("abort_hi", md.hi, 32'd0);
    check("abort_lo", md.lo, 32'd0);
    run_op(3'd1, 32'd3, 32'd4, bc);
    check("post_abort_lo", md.lo, 32'd12);
    check("post_abort_hi", md.hi, 32'd0);

    // start coincident with reset is not accepted
    @(negedge clk);
    rst = 1'b1; md.start = 1'b1; md.op = 3'd0; md.a = 32'd9; md.b = 32'd9;
    @(negedge clk);
    rst = 1'b0; md.start = 1'b0;
    check("start_with_rst_busy", 32'(md.busy), 32'd0);
    check("start_with_rst_lo", md.lo, 32'd0);
    @(negedge clk);
    check("start_with_rst_busy_later", 32'(md.busy), 32'd0);

    // random ops against the arithmetic model
    m_hi = 32'd0; m_lo = 32'd0;
    for (int k = 0; k < 60; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: ra = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      r64 = model(rop, ra, rb, m_hi, m_lo);
      m_hi = r64[63:32];
      m_lo = r64[31:0];
      run_op(rop, ra, rb, bc);
      check($sformatf("rand%0d_op%0d_busy_cycles", k, rop), 32'(bc),
            (rop <= 3'd3) ? 32'd32 : 32'd0);
      check($sformatf("rand%0d_op%0d_hi a=%08h b=%08h", k, rop, ra, rb), md.hi, m_hi);
      check($sformatf("rand%0d_op%0d_lo a=%08h b=%08h", k, rop, ra, rb), md.lo, m_lo);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
